// File: rtl/common_pkg.sv
// Shared front-end types: bus request/response, fetch/decode pipeline register,
// fetch controller states and the reset PC.
package common;

   localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      START = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] raw_instr;
      logic        is_bubble;
   } fetch_data_t;

   // Instructions are word aligned; the low two target bits carry no meaning.
   function automatic logic [63:0] align_pc(input logic [63:0] pc);
      return {pc[63:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry skid register holding an instruction that returned from the bus
// while decode was stalled.
module fetch_buffer
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic        clear,
   input  logic [63:0] ld_pc,
   input  logic [31:0] ld_instr,
   output logic        valid,
   output logic [63:0] pc,
   output logic [31:0] raw_instr
);

   logic        valid_r;
   logic [63:0] pc_r;
   logic [31:0] instr_r;

   // Capture on load; clear only invalidates, the stale payload is never read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_r <= 1'b0;
         pc_r    <= 64'd0;
         instr_r <= 32'd0;
      end else if (load) begin
         valid_r <= 1'b1;
         pc_r    <= ld_pc;
         instr_r <= ld_instr;
      end else if (clear) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign valid     = valid_r;
   assign pc        = pc_r;
   assign raw_instr = instr_r;

endmodule

// File: rtl/fetch.sv
// RV64 instruction fetch: owns the PC, runs one bus transaction at a time and
// drives the fetch/decode register, absorbing stalls and in-flight redirects.
module fetch #(
   parameter logic [63:0] PCINIT = common::PCINIT
) (
   input  logic                clk,
   input  logic                reset_n,
   output common::ibus_req_t   ireq,
   input  common::ibus_resp_t  iresp,
   input  logic                stall,
   input  logic                redirect,
   input  logic [63:0]         redirect_pc,
   output common::fetch_data_t dataF
);

   import common::*;

   fetch_state_t state_r, state_nxt_s;
   logic [63:0]  pc_r, pc_nxt_s;
   logic [63:0]  tgt_r, tgt_nxt_s;
   logic [63:0]  redir_tgt_s;
   fetch_data_t  dataf_r, dataf_nxt_s;
   ibus_req_t    ireq_r, ireq_nxt_s;
   logic         buf_load_s, buf_clear_s, buf_valid_s;
   logic [63:0]  buf_pc_s;
   logic [31:0]  buf_instr_s;
   logic         unused_addr_ok_s;

   assign redir_tgt_s      = align_pc(redirect_pc);
   // The bus never raises data_ok before addr_ok, so only data_ok steers control.
   assign unused_addr_ok_s = iresp.addr_ok;

   fetch_buffer u_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (buf_load_s),
      .clear     (buf_clear_s),
      .ld_pc     (pc_r),
      .ld_instr  (iresp.data),
      .valid     (buf_valid_s),
      .pc        (buf_pc_s),
      .raw_instr (buf_instr_s)
   );

   // State, PC, pending redirect target and the registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= START;
         pc_r    <= PCINIT;
         tgt_r   <= 64'd0;
         dataf_r <= '{pc: 64'd0, raw_instr: 32'd0, is_bubble: 1'b1};
         ireq_r  <= '{valid: 1'b0, addr: PCINIT};
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         tgt_r   <= tgt_nxt_s;
         dataf_r <= dataf_nxt_s;
         ireq_r  <= ireq_nxt_s;
      end
   end

   // Next state, next PC and redirect target; redirect outranks everything.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      tgt_nxt_s   = tgt_r;
      case (state_r)
         START: begin
            state_nxt_s = FETCH;
         end
         FETCH: begin
            if (redirect) begin
               if (iresp.data_ok) begin
                  pc_nxt_s = redir_tgt_s;
               end else begin
                  tgt_nxt_s   = redir_tgt_s;
                  state_nxt_s = DRAIN;
               end
            end else if (iresp.data_ok) begin
               pc_nxt_s    = pc_r + 64'd4;
               state_nxt_s = stall ? HOLD : FETCH;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_nxt_s    = redir_tgt_s;
               state_nxt_s = FETCH;
            end else if (!stall) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         DRAIN: begin
            // The stale response completes the old transaction; the newest target wins.
            if (iresp.data_ok) begin
               pc_nxt_s    = redirect ? redir_tgt_s : tgt_r;
               state_nxt_s = FETCH;
            end else if (redirect) begin
               tgt_nxt_s = redir_tgt_s;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = START;
         end
      endcase
   end

   // Decode-register update, skid buffer control and the next bus request.
   always_comb begin
      dataf_nxt_s = dataf_r;
      buf_load_s  = 1'b0;
      buf_clear_s = 1'b0;
      case (state_r)
         START, DRAIN: begin
            if (!stall) begin
               dataf_nxt_s.is_bubble = 1'b1;
            end else begin
               dataf_nxt_s = dataf_r;
            end
         end
         FETCH: begin
            if (redirect) begin
               dataf_nxt_s = dataf_r;
            end else if (iresp.data_ok) begin
               if (stall) begin
                  buf_load_s = 1'b1;
               end else begin
                  dataf_nxt_s = '{pc: pc_r, raw_instr: iresp.data, is_bubble: 1'b0};
               end
            end else if (!stall) begin
               dataf_nxt_s.is_bubble = 1'b1;
            end else begin
               dataf_nxt_s = dataf_r;
            end
         end
         HOLD: begin
            if (redirect) begin
               buf_clear_s = 1'b1;
            end else if (!stall) begin
               buf_clear_s = 1'b1;
               dataf_nxt_s = '{pc: buf_pc_s, raw_instr: buf_instr_s, is_bubble: !buf_valid_s};
            end else begin
               dataf_nxt_s = dataf_r;
            end
         end
         default: begin
            dataf_nxt_s.is_bubble = 1'b1;
         end
      endcase
      dataf_nxt_s.is_bubble = dataf_nxt_s.is_bubble | redirect;

      ireq_nxt_s.valid = (state_nxt_s == FETCH) || (state_nxt_s == DRAIN);
      ireq_nxt_s.addr  = pc_nxt_s;
   end

   assign ireq  = ireq_r;
   assign dataF = dataf_r;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: a randomized bus/back-end drives the stage while a program-order
// model predicts the instruction stream that decode must see.
module tb_fetch;

   import common::*;

   localparam logic [63:0] PC0 = 64'h0000_0000_8000_0000;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   ibus_req_t   ireq;
   ibus_resp_t  iresp;
   logic        stall;
   logic        redirect;
   logic [63:0] redirect_pc;
   fetch_data_t dataF;

   int          n_checks = 0;
   int          n_pass = 0;
   int          delivered = 0;
   exp_t        expq[$];
   logic [63:0] model_next;
   bit          redir_pending = 1'b0;
   logic [63:0] redir_tgt;
   int          lat_force = 0;
   int          lat_max = 0;
   int          stall_pct = 0;
   int          redir_pct = 0;
   bit          stall_force = 1'b0;
   bit          redir_force = 1'b0;
   logic [63:0] force_tgt = 64'd0;
   bit          done = 1'b0;

   fetch #(.PCINIT(PC0)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ireq        (ireq),
      .iresp       (iresp),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .dataF       (dataF)
   );

   always #5 clk = ~clk;

   // Memory image: every word address holds a distinct pattern.
   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[33:2] ^ a[63:32] ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Stimulus: bus responder, stall/redirect generator and program-order model.
   initial begin : stim
      bit          busy;
      int          lat;
      logic [63:0] busy_addr;
      busy = 1'b0;
      lat = 0;
      busy_addr = 64'd0;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 64'd0;
      iresp = '{addr_ok: 1'b0, data_ok: 1'b0, data: 32'd0};
      model_next = PC0;
      forever begin
         @(posedge clk);
         if (redir_pending) begin
            expq.delete();
            model_next = redir_tgt & ~64'd3;
            redir_pending = 1'b0;
         end
         while (expq.size() < 8) begin
            expq.push_back('{pc: model_next, instr: instr_of(model_next)});
            model_next = model_next + 64'd4;
         end
         #1;
         iresp = '{addr_ok: 1'b0, data_ok: 1'b0, data: 32'd0};
         if (!reset_n) begin
            busy = 1'b0;
            stall = 1'b0;
            redirect = 1'b0;
         end else begin
            if (busy) begin
               chk("bus_valid_held", ireq.valid, 1'b1);
               chk("bus_addr_stable", ireq.addr, busy_addr);
            end
            if (ireq.valid) begin
               if (!busy) begin
                  busy = 1'b1;
                  lat = (lat_force >= 0) ? lat_force : int'($urandom_range(lat_max, 0));
                  busy_addr = ireq.addr;
               end
               iresp.addr_ok = 1'b1;
               if (lat == 0) begin
                  iresp.data_ok = 1'b1;
                  iresp.data = instr_of(ireq.addr);
                  busy = 1'b0;
               end else begin
                  lat--;
               end
            end else begin
               busy = 1'b0;
            end
            stall = stall_force || (int'($urandom_range(99, 0)) < stall_pct);
            redirect = redir_force || (int'($urandom_range(99, 0)) < redir_pct);
            if (redirect) begin
               if (redir_force) redirect_pc = force_tgt;
               else if ($urandom_range(7, 0) == 0)
                  redirect_pc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31, 0));
               else redirect_pc = {$urandom(), $urandom()};
               redir_pending = 1'b1;
               redir_tgt = redirect_pc;
            end
         end
      end
   end

   // Monitor: each fresh instruction in dataF is popped from the model stream.
   initial begin : monitor
      bit          s_stall, s_redir, s_rst;
      fetch_data_t prev;
      exp_t        e;
      prev = dataF;
      forever begin
         @(posedge clk);
         s_stall = stall;
         s_redir = redirect;
         s_rst = reset_n;
         @(negedge clk);
         if (!done && s_rst && reset_n) begin
            if (s_redir) begin
               chk("redirect_bubble", dataF.is_bubble, 1'b1);
            end else if (s_stall) begin
               chk("stall_hold_pc", dataF.pc, prev.pc);
               chk("stall_hold_ins", {dataF.raw_instr, dataF.is_bubble}, {prev.raw_instr, prev.is_bubble});
            end else if (!dataF.is_bubble) begin
               delivered++;
               chk("stream_nonempty", expq.size() > 0, 1'b1);
               if (expq.size() > 0) begin
                  e = expq.pop_front();
                  chk("stream_pc", dataF.pc, e.pc);
                  chk("stream_instr", dataF.raw_instr, e.instr);
               end
            end
         end
         prev = dataF;
      end
   end

   // Directed scenarios, then a randomized run, then an asynchronous reset.
   initial begin : main
      fetch_data_t snap;
      int          d0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_valid", ireq.valid, 1'b0);
      chk("rst_addr", ireq.addr, PC0);
      chk("rst_bubble", dataF.is_bubble, 1'b1);
      chk("rst_dpc", dataF.pc, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("start_no_req", ireq.valid, 1'b0);
      @(posedge clk);
      #2 chk("first_req_valid", ireq.valid, 1'b1);
      chk("first_req_addr", ireq.addr, PC0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #2 chk("burst_pc", dataF.pc, PC0 + 64'(4 * k));
         chk("burst_valid", dataF.is_bubble, 1'b0);
      end

      // Stall for three cycles while the next instruction returns.
      @(posedge clk);
      stall_force = 1'b1;
      @(negedge clk);
      snap = dataF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         if (i == 2) stall_force = 1'b0;
         #2 chk("hold_pc", dataF.pc, snap.pc);
         chk("hold_no_req", ireq.valid, 1'b0);
      end
      @(posedge clk);
      lat_force = 4;
      #2 chk("unstall_pc", dataF.pc, snap.pc + 64'd4);
      chk("unstall_valid", dataF.is_bubble, 1'b0);

      // Redirect with a slow transaction outstanding.
      @(posedge clk);
      redir_force = 1'b1;
      force_tgt = 64'h0000_0000_8000_1002;
      @(posedge clk);
      redir_force = 1'b0;
      #2 chk("drain_addr_held", ireq.addr, snap.pc + 64'd8);
      chk("drain_req", ireq.valid, 1'b1);
      repeat (3) @(posedge clk);
      #2 chk("post_drain_addr", ireq.addr, 64'h0000_0000_8000_1000);
      chk("post_drain_valid", ireq.valid, 1'b1);

      // Two redirects while draining: only the last target is fetched.
      @(posedge clk);
      redir_force = 1'b1;
      force_tgt = 64'h0000_0000_8000_2000;
      @(posedge clk);
      force_tgt = 64'h0000_0000_8000_3000;
      @(posedge clk);
      redir_force = 1'b0;
      @(posedge clk);
      @(posedge clk);
      lat_force = 0;
      #2 chk("drain2_addr", ireq.addr, 64'h0000_0000_8000_3000);
      chk("drain2_valid", ireq.valid, 1'b1);

      // Redirect under stall while an instruction sits in the skid buffer; target wraps.
      @(posedge clk);
      stall_force = 1'b1;
      @(posedge clk);
      redir_force = 1'b1;
      force_tgt = 64'hFFFF_FFFF_FFFF_FFFE;
      @(posedge clk);
      redir_force = 1'b0;
      #2 chk("hold_redir_bubble", dataF.is_bubble, 1'b1);
      chk("hold_redir_addr", ireq.addr, 64'hFFFF_FFFF_FFFF_FFFC);
      @(posedge clk);
      stall_force = 1'b0;

      lat_force = -1;
      lat_max = 4;
      stall_pct = 25;
      redir_pct = 6;
      d0 = delivered;
      repeat (3000) @(posedge clk);
      stall_pct = 0;
      redir_pct = 0;
      repeat (30) @(posedge clk);
      chk("progress", (delivered - d0) > 200, 1'b1);

      // Reset in the middle of a transaction.
      lat_force = 3;
      @(posedge clk);
      @(posedge clk);
      #3 chk("pre_reset_valid", ireq.valid, 1'b1);
      done = 1'b1;
      reset_n = 1'b0;
      #1 chk("async_valid", ireq.valid, 1'b0);
      chk("async_bubble", dataF.is_bubble, 1'b1);
      chk("async_addr", ireq.addr, PC0);
      repeat (2) @(posedge clk);
      #2 chk("rst_hold_valid", ireq.valid, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
